// File: rtl/queue_buffer.sv
// rtl/queue_buffer.sv - WIDTH x DEPTH buffer with run-time FIFO/LIFO ordering and four-phase handshakes
module queue_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       mode,
    input  logic                       tx_rdy,
    output logic                       tx_done,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       rx_rdy,
    input  logic                       rx_done,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    typedef enum logic {T_IDLE, T_ACK} tx_state_t;
    typedef enum logic {R_IDLE, R_ACK} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    front, back, back_dec, wr_idx;
    logic             mode_q;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    assign back_dec = (back == '0) ? LAST_P : back - PW'(1);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);

    assign tx_done = (tx_state == T_ACK);
    assign rx_rdy  = (rx_state == R_IDLE) && !empty;
    assign push    = (tx_state == T_IDLE) && tx_rdy && !full && !flush;
    assign pop     = rx_rdy && rx_done && !flush;

    // LIFO push+pop replaces the current top instead of moving back
    assign wr_idx   = (pop && mode_q) ? back_dec : back;
    assign out_data = empty ? '0 : (mode_q ? mem[back_dec] : mem[front]);

    always_comb begin
        tx_next = tx_state;
        rx_next = rx_state;
        case (tx_state)
            T_IDLE:  if (push)    tx_next = T_ACK;
            default: if (!tx_rdy) tx_next = T_IDLE;
        endcase
        case (rx_state)
            R_IDLE:  if (pop)      rx_next = R_ACK;
            default: if (!rx_done) rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            rx_state <= R_IDLE;
            front    <= '0;
            back     <= '0;
            count    <= '0;
            mode_q   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
            if (count == '0 && !push)
                mode_q <= mode;
            if (flush) begin
                front <= '0;
                back  <= '0;
                count <= '0;
            end else begin
                if (push && pop) begin
                    if (!mode_q) begin
                        front <= ptr_inc(front);
                        back  <= ptr_inc(back);
                    end
                end else if (push) begin
                    back  <= ptr_inc(back);
                    count <= count + CW'(1);
                end else if (pop) begin
                    if (mode_q) back  <= back_dec;
                    else        front <= ptr_inc(front);
                    count <= count - CW'(1);
                end
                // Realign pointers on an ordering change so the new mode starts from slot 0
                if (count == '0 && !push && mode != mode_q) begin
                    front <= '0;
                    back  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_idx] <= in_data;
    end

endmodule

// File: doc/queue_buffer.md
# queue_buffer

Parametrised successor to the team's 5-entry stack: a WIDTH×DEPTH storage buffer with a run-time-selectable FIFO or LIFO ordering. It uses the same two-sided tx_rdy/tx_done and rx_rdy/rx_done four-phase handshake, and adds an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It sits between a producer and a consumer that each run the handshake on the shared clock.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 5, number of entries; any value ≥ 2, power of two not required
- AFULL_TH, DEPTH-1, almost_full asserted when count ≥ AFULL_TH
- AEMPTY_TH, 1, almost_empty asserted when count ≤ AEMPTY_TH
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- flush  in  1  synchronous clear of contents (1 cycle pulse)
- mode  in  1  0 = FIFO, 1 = LIFO; sampled only while empty
- tx_rdy  in  1  producer has a word on in_data
- tx_done  out  1  word accepted; held until tx_rdy drops
- in_data  in  WIDTH  write data
- rx_rdy  out  1  out_data valid, consumer may take it
- rx_done  in  1  consumer has taken out_data
- out_data  out  WIDTH  head word (FIFO oldest / LIFO newest); 0 when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- empty, full, almost_empty, almost_full  out  1 each  occupancy flags

## Operation
- Storage: DEPTH-entry array, write pointer back, read pointer front, both 0..DEPTH-1. Pointers wrap explicitly (DEPTH-1 → 0), not by bit truncation.
- Mode register mode_q: loads mode on any edge where count = 0 and no push occurs. It is ignored while non-empty.
- FIFO: a push writes buffer[back] and then increments back. A pop increments front. Head is buffer[front].
- LIFO: a push writes buffer[back] and then increments back. A pop decrements back. Head is buffer[back-1], with wrap. front is unused and held at 0.
- TX FSM, states T_IDLE and T_ACK:
  - In T_IDLE, tx_rdy=1 with full=0 causes a push, sets tx_done=1 and moves to T_ACK.
  - In T_ACK, tx_rdy=0 clears tx_done and returns to T_IDLE. This gives exactly one push per tx_rdy assertion.
  - tx_rdy while full stalls in T_IDLE. tx_done stays 0 and the push completes on the first edge where full=0.
- RX FSM, states R_IDLE and R_ACK:
  - rx_rdy = (rx_state = R_IDLE) && !empty, a decode of registered state.
  - rx_rdy=1 with rx_done=1 causes a pop and moves to R_ACK.
  - In R_ACK, rx_done=0 returns to R_IDLE.
- Simultaneous push and pop: both are performed and count is unchanged.
  - FIFO: independent pointers.
  - LIFO: the pop removes the current top and the new word overwrites slot back-1; back is unchanged.
- A push is gated by full at the start of the cycle only; a concurrent pop does not unblock it.
- count is incremented, decremented or held. Flags are pure decodes of count.

## Timing
- Reset values:
  - tx_done=0, rx_rdy=0, out_data=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - front=back=0, mode_q=0, both FSMs idle.
  - Memory contents are not reset.
- rst has priority over everything, including an in-progress handshake. After reset the producer and consumer must restart their handshakes.
- flush:
  - Next edge sets count/front/back to 0.
  - Any push or pop that edge is suppressed: tx_done not raised, no transition to R_ACK.
  - FSMs already in an ACK state complete normally.
- Push latency: tx_done is high and count updated one edge after tx_rdy is sampled high. rx_rdy rises on the same edge if the buffer was empty.
- Pop latency: rx_rdy falls, and count and out_data update, on the edge that samples rx_done=1.
- out_data is combinational from storage and the pointers, forced to 0 when empty.

## Test plan
- Reset/idle: hold rst 3 cycles with tx_rdy=1 → tx_done=0, rx_rdy=0, count=0, empty=1, almost_empty=1, out_data=0. After release, the first push of 0x24 gives count=1 and rx_rdy=1 one edge later.
- FIFO fill/drain, DEPTH=5, mode=0:
  - Push 0x11, 0x22, 0x33, 0x44, 0x55 → full=1 and almost_full set at count=4.
  - A 6th tx_rdy stalls with tx_done=0.
  - Pops return 0x11..0x55 in order. back and front wrap 4→0 on a second fill.
- LIFO, mode=1: push 0x11..0x55, then pop 5 → 0x55, 0x44, 0x33, 0x22, 0x11, ending with empty=1. Driving mode=0 mid-fill is ignored.
- Simultaneous push and pop at count=3: FIFO gives count=3 with head advanced. LIFO gives count=3 with out_data equal to the new word.
- Flush at count=4 during an active push → count=0, empty=1, no tx_done, stored data discarded. A subsequent mode change takes effect.
- Handshake hold: keep tx_rdy high for 10 cycles → exactly one push, with tx_done held high until tx_rdy drops.
